// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner
//
// Reads a packed vector of BCD digits and drives a common-anode, time-multiplexed
// seven-segment display. bcd_in is captured into a shadow register on load. The
// display only ever reads the shadow register. A prescaler spends SCAN_DIV cycles
// on each digit. The scan runs from digit 0 up to DIGITS-1 and then wraps back to 0.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   bcd_in     packed digits; digit 0 sits at [3:0]
//   load       captures bcd_in into the shadow register
//   seg        {g,f,e,d,c,b,a}, active-low, registered
//   an         anode enables, active-low, one-hot-low while a digit is driven
//   digit_idx  index of the digit currently on an/seg
//   err        high while the shadow register holds any code above 9
//
// Build option:
//   BCD_SCAN_LZB_EN  compiles in leading-zero blanking. Each load also registers a
//                    blank mask. Digit 0 is never blanked. Codes above 9 count as
//                    nonzero.
module bcd_display_scanner #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [4*DIGITS-1:0]        bcd_in,
  input  logic                       load,
  output logic [6:0]                 seg,
  output logic [DIGITS-1:0]          an,
  output logic [$clog2(DIGITS)-1:0]  digit_idx,
  output logic                       err
);

  localparam int unsigned IdxW = $clog2(DIGITS);
  localparam int unsigned PscW = $clog2(SCAN_DIV);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);
  localparam logic [PscW-1:0] LastPsc = PscW'(SCAN_DIV - 1);

  function automatic logic [6:0] decode(input logic [3:0] code);
    unique case (code)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;  // dash for codes 10-15
    endcase
  endfunction

  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [PscW-1:0]     presc_q, presc_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0]   blank_q;

  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [IdxW-1:0]     didx_q;
  logic                err_q, err_d;

  logic [3:0]          cur_code;
  logic                cur_blank;
  logic                presc_wrap;

`ifdef BCD_SCAN_LZB_EN
  // Digit k (k >= 1) is blanked when it and every more-significant digit are zero.
  function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] v);
    logic lead;
    lead    = 1'b1;
    lz_mask = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      lead       = lead & (v[4*k +: 4] == 4'd0);
      lz_mask[k] = lead;
    end
  endfunction

  logic [DIGITS-1:0] blank_d;

  always_comb begin
    blank_d = load ? lz_mask(bcd_in) : blank_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blank_q <= lz_mask('0);  // matches the zeroed shadow
    end else begin
      blank_q <= blank_d;
    end
  end
`else
  assign blank_q = '0;
`endif

  // Prescaler, scan index and shadow capture. A load and a wrap on the same edge
  // both take effect, so the digit after the advance is decoded from the new value.
  always_comb begin
    presc_wrap = (presc_q == LastPsc);
    presc_d    = presc_wrap ? '0 : presc_q + PscW'(1);
    idx_d      = idx_q;
    if (presc_wrap) begin
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
    end
    shadow_d = load ? bcd_in : shadow_q;
  end

  // The output stage decodes the registered shadow and index, so it trails them by
  // one cycle.
  always_comb begin
    cur_code  = 4'd0;
    cur_blank = 1'b0;
    err_d     = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx_q == IdxW'(k)) begin
        cur_code  = shadow_q[4*k +: 4];
        cur_blank = blank_q[k];
      end
      if (shadow_q[4*k +: 4] > 4'd9) begin
        err_d = 1'b1;
      end
    end
    seg_d = cur_blank ? 7'b1111111 : decode(cur_code);
    an_d  = '1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (!cur_blank && idx_q == IdxW'(k)) begin
        an_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_q <= '0;
      presc_q  <= '0;
      idx_q    <= '0;
      seg_q    <= 7'b1111111;
      an_q     <= '1;
      didx_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      didx_q   <= idx_q;
      err_q    <= err_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign digit_idx = didx_q;
  assign err       = err_q;

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Multi-digit BCD display reader that sits downstream of the BCD counters and drives a common-anode, time-multiplexed seven-segment display. It captures a packed vector of BCD digits on a load strobe, then scans the digits one at a time, decoding each to segment patterns. Invalid codes are flagged, and leading zeros are optionally blanked.

## Interface
- `DIGITS`, default 4: number of BCD digits and anodes; must be ≥ 2.
- `SCAN_DIV`, default 1000: clock cycles each digit is driven; must be ≥ 2.
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset_n` input 1: synchronous reset, active-low.
- `bcd_in` input 4*DIGITS: packed digits; digit 0 (least significant) is at `[3:0]`.
- `load` input 1: capture `bcd_in` into the shadow register on this edge.
- `seg` output 7: `{g,f,e,d,c,b,a}`, active-low.
- `an` output DIGITS: anode enables, active-low, one-hot-low when driving a digit.
- `digit_idx` output clog2(DIGITS): index of the digit currently on `an`/`seg`.
- `err` output 1: high while the shadow register holds any code greater than 9.

## Operation
- **Shadow register:**
  - Loads `bcd_in` on any edge with `load=1`.
  - Holds its value otherwise.
  - The display never reads `bcd_in` directly.
- **Prescaler:**
  - Counts 0 to SCAN_DIV-1, then wraps to 0.
  - On wrap, the scan index advances. It counts DIGITS-1 → 0 (wrap-around), then continues 0 → 1.
- **Decode (active-low):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes 10–15 display a dash (0111111) and contribute to `err`.
- **`err`:** registered; recomputed on every load from the captured value; cleared only by a load with all digits valid.
- **Output stage:** `an` drives low only the bit at the scan index; all other bits stay high.
- **Blanking:** a blanked digit drives `an` all-ones and `seg`=1111111. The scan still spends SCAN_DIV cycles on it.
- **Simultaneous load and prescaler wrap:** both take effect. The digit driven after the advance uses the new shadow value.
- **Reset mid-scan:** discards the shadow, the index and any pending state immediately.

## Timing
- **Reset values** (in the cycle after the reset edge):
  - `seg`=1111111, `an`=all-ones, `digit_idx`=0, `err`=0
  - shadow=0, prescaler=0, scan index=0
- **First drive:** the first digit 0 drive appears at edge 2 after `reset_n` deasserts, showing "0".
- **Registered outputs:** `seg`, `an` and `digit_idx` are registered from the shadow register and scan index.
  - Scan index change at edge t: outputs show the new digit at edge t+1.
  - `load` at edge t: shadow updates at t, `seg` reflects it at t+1, and `err` updates at t+1.
- **Scan rate:** each digit is driven for exactly SCAN_DIV consecutive cycles. A full refresh takes DIGITS*SCAN_DIV cycles.
- **No ghosting:** an anode transition never overlaps two active-low bits in the same cycle.

## Configuration
- **`BCD_SCAN_LZB_EN` defined:** leading-zero blanking is compiled in.
  - On each load, a blank mask is computed and registered alongside the shadow.
  - Digit k is blanked when it and all more-significant digits are 0.
  - Digit 0 is never blanked, so an all-zero value shows a single "0".
  - Invalid codes count as nonzero.
- **Macro undefined:** the mask logic is absent and every digit is always displayed, including zeros.

## Test plan
Test bench uses DIGITS=4 and SCAN_DIV=4.
- **Reset:**
  - Stimulus: hold `reset_n`=0 for 3 cycles with `load`=1 and `bcd_in`=16'h1234.
  - Required: `an`=1111, `seg`=1111111, `err`=0 throughout.
  - After release: `an`=1110 with `seg`=1000000.
- **Scan order:**
  - Stimulus: load 16'h4321 and observe a 16-cycle window.
  - Required: `an` steps 1110→1101→1011→0111, 4 cycles each.
  - Required: `seg` is 1111001, 0100100, 0110000, 0011001 respectively.
  - Required: the pattern then wraps to 1110.
- **Invalid code:**
  - Stimulus: load 16'h9A05.
  - Required: `err`=1 one cycle after the load, and digit 2 shows 0111111.
  - Then load 16'h0009: required `err`=0 one cycle after that load.
- **Load at prescaler wrap:**
  - Stimulus: assert `load` with 16'h8888 on the edge where digit 1 → digit 2.
  - Required: digit 2 shows 0000000 from its first cycle.
- **Leading-zero blanking** (`BCD_SCAN_LZB_EN` defined):
  - Stimulus: load 16'h0050.
  - Required: digits 3 and 2 drive `an`=1111 and `seg`=1111111; digit 1 shows 0010010; digit 0 shows 1000000.
  - Stimulus: load 16'h0000. Required: only digit 0 is lit.
  - Without the macro: all four digits are lit.
- **Reset mid-scan:**
  - Stimulus: pulse `reset_n`=0 for 1 cycle during digit 2.
  - Required: the next output is all off, followed by digit 0 showing "0" with `err`=0.
